// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO read-side drain engine.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned SKID_DEPTH      = 2;

    // Skid buffer occupancy doubles as its state encoding.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry register skid buffer: writes land at the tail, the head is presented registered.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       occ_o
);

    occ_e             occ_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (wr_i) begin
                        head_q <= wr_data_i;
                        occ_q  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    // Write+pop bypasses straight into the head slot.
                    if (wr_i && pop_i) begin
                        head_q <= wr_data_i;
                    end else if (wr_i) begin
                        tail_q <= wr_data_i;
                        occ_q  <= OCC_TWO;
                    end else if (pop_i) begin
                        occ_q  <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop_i) begin
                        head_q <= tail_q;
                        if (wr_i) begin
                            tail_q <= wr_data_i;
                        end else begin
                            occ_q  <= OCC_ONE;
                        end
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ni) begin
            assert (!(wr_i && !pop_i && occ_q == OCC_TWO))
                else $error("fifo_rd_skid: write into full buffer without pop");
        end
    end

    assign head_o = head_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: issues FIFO reads, absorbs read latency, streams words out valid/ready.
// Optional FIFO_RD_STATS_EN adds rd_words/rd_stalls counters.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
    parameter int unsigned SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           rd_words,
    output logic [31:0]           rd_stalls
`endif
);

    import fifo_pkg::*;

    if (SKID_DEPTH != 2) begin : g_depth_check
        $error("fifo_rd_stream: SKID_DEPTH must be 2");
    end

    logic                  inflight_q;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop_c;
    logic                  issue_c;
    logic [2:0]            fill_c;

    // Occupancy after this cycle; a read is only issued if its word will have a slot.
    assign pop_c   = m_valid & m_ready;
    assign fill_c  = 3'(occ) + 3'(inflight_q) - 3'(pop_c);
    assign issue_c = rst & ~fifo_empty & (fill_c < 3'(SKID_DEPTH));

    assign fifo_r_en = issue_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue_c;
        end
    end

    fifo_rd_skid #(
        .WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_ni   (rst),
        .wr_i     (inflight_q),
        .wr_data_i(fifo_dout),
        .pop_i    (pop_c),
        .head_o   (head),
        .occ_o    (occ)
    );

    assign m_valid = (occ != 2'(OCC_EMPTY));
    assign m_data  = head;

`ifdef FIFO_RD_STATS_EN
    logic [31:0] rd_words_q;
    logic [31:0] rd_stalls_q;

    // Word count wraps; stall count saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_words_q  <= '0;
            rd_stalls_q <= '0;
        end else begin
            if (pop_c) begin
                rd_words_q <= rd_words_q + 32'd1;
            end
            if (m_valid && !m_ready && rd_stalls_q != 32'hFFFF_FFFF) begin
                rd_stalls_q <= rd_stalls_q + 32'd1;
            end
        end
    end

    assign rd_words  = rd_words_q;
    assign rd_stalls = rd_stalls_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO source plus queue model of the outstanding words.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_r_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [31:0]   rd_words;
    logic [31:0]   rd_stalls;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_r_en (fifo_r_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_words  (rd_words),
        .rd_stalls (rd_stalls)
`endif
    );

    logic [DW-1:0] src[$];       // words sitting in the FIFO
    logic [DW-1:0] mdl_buf[$];   // words captured but not yet delivered
    bit            mdl_inflight;
    logic [DW-1:0] mdl_word;
    int unsigned   exp_words;
    int unsigned   exp_stalls;
    int unsigned   total = 0;
    int unsigned   bad   = 0;
    int            cyc   = 0;
    int            ren_cyc[$];
    int            pop_cyc[$];
    logic [DW-1:0] pop_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock: mode 0 = natural empty, 1 = force empty, 2 = force non-empty.
    task automatic step(input bit rst_v, input bit rdy, input int mode, input bit chk);
        bit            exp_valid;
        bit            exp_pop;
        bit            exp_ren;
        bit            act_ren;
        int            fill;
        logic [DW-1:0] w;
        rst        = rst_v;
        m_ready    = rdy;
        fifo_empty = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (src.size() == 0);
        @(negedge clk);
        exp_valid = (mdl_buf.size() != 0);
        exp_pop   = exp_valid && rdy;
        fill      = mdl_buf.size() + int'(mdl_inflight) - int'(exp_pop);
        exp_ren   = rst_v && !fifo_empty && (fill < 2);
        if (chk) begin
            check("m_valid", 32'(m_valid), 32'(exp_valid));
            check("r_en", 32'(fifo_r_en), 32'(exp_ren));
            if (exp_pop) check("m_data", 32'(m_data), 32'(mdl_buf[0]));
`ifdef FIFO_RD_STATS_EN
            check("rd_words", rd_words, exp_words);
            check("rd_stalls", rd_stalls, exp_stalls);
`endif
        end
        act_ren = fifo_r_en;
        if (act_ren) ren_cyc.push_back(cyc);
        if (m_valid && m_ready && rst_v) begin
            pop_cyc.push_back(cyc);
            pop_data.push_back(m_data);
        end
        @(posedge clk);
        w = 8'($urandom);
        if (act_ren && src.size() != 0) w = src.pop_front();
        if (!rst_v) begin
            mdl_buf.delete();
            mdl_inflight = 1'b0;
            exp_words    = 0;
            exp_stalls   = 0;
        end else begin
            if (exp_pop) exp_words++;
            if (exp_valid && !rdy && exp_stalls != 32'hFFFF_FFFF) exp_stalls++;
            if (exp_pop) void'(mdl_buf.pop_front());
            if (mdl_inflight) mdl_buf.push_back(mdl_word);
            mdl_inflight = exp_ren;
            mdl_word     = w;
        end
        #1;
        fifo_dout = act_ren ? w : 8'($urandom);
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((src.size() != 0 || mdl_buf.size() != 0 || mdl_inflight) && n < budget) begin
            step(1'b1, 1'b1, 0, 1'b1);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic clear_rec();
        ren_cyc.delete();
        pop_cyc.delete();
        pop_data.delete();
    endtask

    initial begin
        int n;
        int pushed;
        int ren_before;
        rst        = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        exp_words  = 0;
        exp_stalls = 0;

        // 1. Reset with a non-empty FIFO flag
        step(1'b0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2, 1'b1);
            check("rst_m_data", 32'(m_data), 32'd0);
            check("rst_m_valid", 32'(m_valid), 32'd0);
        end

        // 2. Streaming 11..18
        clear_rec();
        for (int i = 0; i < 8; i++) src.push_back(8'(8'h11 + i));
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 0, 1'b1);
        check("str_ren_cnt", 32'(ren_cyc.size()), 32'd8);
        check("str_pop_cnt", 32'(pop_cyc.size()), 32'd8);
        if (ren_cyc.size() == 8 && pop_cyc.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("str_ren_cyc", 32'(ren_cyc[i]), 32'(ren_cyc[0] + i));
                check("str_pop_cyc", 32'(pop_cyc[i]), 32'(ren_cyc[0] + 2 + i));
                check("str_data", 32'(pop_data[i]), 32'(8'h11 + i));
            end
        end

        // 3. Backpressure from the second word
        clear_rec();
        for (int i = 0; i < 8; i++) src.push_back(8'(8'h21 + i));
        n = 0;
        while (pop_cyc.size() == 0 && n < 10) begin
            step(1'b1, 1'b1, 0, 1'b1);
            n++;
        end
        check("bp_first", 32'(pop_cyc.size()), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b1);
        ren_before = ren_cyc.size();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b1);
        check("bp_ren_held", 32'(ren_cyc.size() - ren_before), 32'd0);
        check("bp_occ", 32'(dut.occ), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_head", 32'(m_data), 32'h22);
        drain("bp_drain", 40);
        check("bp_cnt", 32'(pop_data.size()), 32'd8);
        for (int i = 0; i < pop_data.size() && i < 8; i++)
            check("bp_data", 32'(pop_data[i]), 32'(8'h21 + i));

        // 4. Empty flag toggling every clock
        clear_rec();
        for (int i = 0; i < 8; i++) src.push_back(8'(8'h31 + i));
        n = 0;
        while ((src.size() != 0 || mdl_buf.size() != 0 || mdl_inflight) && n < 40) begin
            step(1'b1, 1'b1, (n % 2 == 1) ? 1 : 0, 1'b1);
            n++;
        end
        check("tog_cnt", 32'(pop_data.size()), 32'd8);
        for (int i = 0; i < pop_data.size() && i < 8; i++)
            check("tog_data", 32'(pop_data[i]), 32'(8'h31 + i));

        // 5. Reset with one word buffered and one in flight
        clear_rec();
        for (int i = 0; i < 8; i++) src.push_back(8'(8'h41 + i));
        step(1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b1);
        check("mid_occ_pre", 32'(dut.occ), 32'd1);
        step(1'b0, 1'b0, 0, 1'b1);
        check("mid_valid", 32'(m_valid), 32'd0);
        check("mid_occ", 32'(dut.occ), 32'd0);
        clear_rec();
        drain("mid_drain", 40);
        check("mid_first", 32'(pop_data.size() != 0 ? pop_data[0] : 8'h00), 32'h43);

`ifdef FIFO_RD_STATS_EN
        // 6. Statistics counters
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        check("st_rst_words", rd_words, 32'd0);
        check("st_rst_stalls", rd_stalls, 32'd0);
        for (int i = 0; i < 5; i++) src.push_back(8'(8'h51 + i));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 1'b1);
        drain("st_drain", 30);
        check("st_words5", rd_words, 32'd5);
        check("st_stalls3", rd_stalls, 32'd3);
        force dut.rd_stalls_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_stalls_q;
        exp_stalls = 32'hFFFF_FFFF;
        src.push_back(8'h66);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 1'b1);
        check("st_sat", rd_stalls, 32'hFFFF_FFFF);
        drain("st_drain2", 20);
`endif

        // Randomized traffic
        clear_rec();
        pushed = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && src.size() < 16) begin
                src.push_back(8'($urandom));
                pushed++;
            end
            step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0) ? 1 : 0, 1'b1);
        end
        drain("rnd_drain", 80);
        check("rnd_conserve", 32'(pop_data.size()), 32'(pushed));
        check("rnd_idle", 32'(m_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
